serial_add_sched: RTL and testbench
===================================

Name: serial_add_sched

Overview:
- Controller that time-shares one combinational 1-bit full-adder cell (a, b, c -> s, cout) between NREQ requesters to perform WIDTH-bit bit-serial additions, LSB first.
- Arbitrates requests round-robin, latches the operands and feeds the adder one bit per cycle.
- Keeps the carry in a flop between cycles and assembles the sum into a shift register.
- Sits between client logic and the gate-level adder netlist, which stays purely combinational.

Parameters:
WIDTH, 8, operand/sum width in bits (>=2)
NREQ, 2, number of requesters (>=2)

Ports:
clk  in  1  single system clock
rst_n  in  1  synchronous active-low reset
req_valid  in  NREQ  request valid per requester; held until accepted
req_ready  out  NREQ  one-hot grant/accept; at most one bit high
req_a  in  NREQ*WIDTH  operand A, requester i at [i*WIDTH +: WIDTH]
req_b  in  NREQ*WIDTH  operand B, same packing
req_cin  in  NREQ  carry-in per requester
fa_a  out  1  adder input a
fa_b  out  1  adder input b
fa_c  out  1  adder carry input
fa_s  in  1  adder sum output (combinational from fa_a/b/c)
fa_cout  in  1  adder carry output
res_valid  out  1  result valid
res_ready  in  1  result consumer ready
res_sum  out  WIDTH  sum bits
res_cout  out  1  final carry-out
res_id  out  clog2(NREQ)  index of requester that owns the result

Behaviour:
- Reset (rst_n low at a clk edge):
  - State goes to IDLE and the bit counter to 0.
  - res_valid, res_sum, res_cout and res_id are all 0.
  - fa_a, fa_b and fa_c are 0; req_ready is all 0 while rst_n is low.
  - The last-grant pointer resets to NREQ-1, so requester 0 has first priority.
- States:
  - IDLE: req_ready = round-robin grant of req_valid, combinational, starting from last_grant+1 and wrapping. On the edge where any req_valid&req_ready is high: latch the operands into shift registers a_sh and b_sh, latch cin into carry, latch the id, update last_grant, clear the counter, go to RUN. With no valid request, stay in IDLE and req_ready = 0.
  - RUN: drive fa_a=a_sh[0], fa_b=b_sh[0], fa_c=carry. Each edge: shift fa_s into sum_sh from the MSB side, set carry<=fa_cout, shift a_sh and b_sh right, increment the counter. On the edge where counter==WIDTH-1, go to DONE. req_ready = 0.
  - DONE: res_valid=1; res_sum=sum_sh, res_cout=carry, res_id=latched id, all stable. When res_valid&res_ready is high at an edge, go to IDLE. req_ready = 0 in DONE; there is no overlap with a new accept.
- Outside RUN, fa_a, fa_b and fa_c are forced to 0 (gated, so no spurious toggling of the adder).
- Latency:
  - Accept at cycle T, RUN during cycles T+1..T+WIDTH, res_valid first high at T+WIDTH+1.
  - Minimum issue interval is WIDTH+2 cycles per transaction (with res_ready held high).
- Arithmetic: {res_cout,res_sum} = req_a + req_b + req_cin, modulo 2^(WIDTH+1); no overflow flag.
- Boundary rules:
  - Simultaneous requests: exactly one is granted, per the round-robin order.
  - A request that is not granted stays pending; the requester holds it.
  - res_ready held low keeps DONE indefinitely with res_* unchanged.
  - Reset mid-RUN or mid-DONE aborts the transaction immediately with no result; the requester must reissue.
  - The counter never exceeds WIDTH-1.
  - req_valid deasserting without a grant is legal and has no effect.

Decomposition:
- Package serial_add_pkg holds:
  - state enum {IDLE, RUN, DONE};
  - default WIDTH/NREQ constants;
  - function clog2.
- Sub-module rr_arb(NREQ): inputs req, last_grant, enable; output one-hot grant plus encoded index. serial_add_sched instantiates it. Pointer storage stays in the parent.
- Bench: a behavioural full adder drives fa_s/fa_cout.

Test Plan:
- Test 1, basic add: req0 a=0x35, b=0x4A, cin=0, accept at T -> res_valid at T+9, res_sum=0x7F, res_cout=0, res_id=0; fa_c=0 in all RUN cycles.
- Test 2, full carry ripple: req1 a=0xFF, b=0x01, cin=0 -> res_sum=0x00, res_cout=1, res_id=1; fa_c=1 from the second RUN cycle on.
- Test 3, carry-in: req0 a=0xFF, b=0xFF, cin=1 -> res_sum=0xFF, res_cout=1.
- Test 4, contention: req0 and req1 valid together after reset -> req0 granted first; req1 granted on the next IDLE; a further simultaneous pair grants req0 again (alternation). req_ready is never 2'b11.
- Test 5, backpressure: res_ready low for 5 cycles after res_valid -> res_valid and res_* stable, req_ready=0 throughout. IDLE is entered the cycle after res_ready rises.
- Test 6, reset mid-operation: rst_n low at RUN bit 3 -> next cycle IDLE, res_valid=0, fa_*=0, last_grant=NREQ-1. A new req0 3+4 then gives res_sum=0x07.

Source files
------------

// File: rtl/serial_add_pkg.sv
// rtl/serial_add_pkg.sv - shared types and constants for the bit-serial adder scheduler
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DEF_WIDTH = 8;
    localparam int DEF_NREQ  = 2;

    // Never returns less than 1 so every derived index vector has at least one bit.
    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/rr_arb.sv
// rtl/rr_arb.sv - combinational round-robin arbiter, search starts one past last_grant
module rr_arb #(
    parameter int NREQ = 2,
    parameter int IDW  = 1
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last_grant,
    input  logic            enable,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_idx
);

    logic           found;
    logic [IDW-1:0] cand;

    always_comb begin
        grant     = '0;
        grant_idx = '0;
        found     = 1'b0;
        cand      = '0;
        for (int off = 1; off <= NREQ; off++) begin
            cand = IDW'((int'(last_grant) + off) % NREQ);
            if (enable && !found && req[cand]) begin
                grant[cand] = 1'b1;
                grant_idx   = cand;
                found       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/serial_add_sched.sv
// rtl/serial_add_sched.sv - time-shares one external full-adder cell among NREQ bit-serial add requesters
module serial_add_sched
    import serial_add_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int NREQ  = DEF_NREQ
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*WIDTH-1:0]    req_a,
    input  logic [NREQ*WIDTH-1:0]    req_b,
    input  logic [NREQ-1:0]          req_cin,
    output logic                     fa_a,
    output logic                     fa_b,
    output logic                     fa_c,
    input  logic                     fa_s,
    input  logic                     fa_cout,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [WIDTH-1:0]         res_sum,
    output logic                     res_cout,
    output logic [clog2(NREQ)-1:0]   res_id
);

    localparam int IDW = clog2(NREQ);
    localparam int CW  = clog2(WIDTH);
    localparam logic [CW-1:0]  CNT_LAST  = CW'(WIDTH - 1);
    localparam logic [IDW-1:0] LAST_INIT = IDW'(NREQ - 1);

    state_t             state_q;
    state_t             state_d;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   a_sh;
    logic [WIDTH-1:0]   b_sh;
    logic [WIDTH-1:0]   sum_sh;
    logic               carry;
    logic [IDW-1:0]     id_q;
    logic [IDW-1:0]     last_grant;
    logic [NREQ-1:0]    grant;
    logic [IDW-1:0]     grant_idx;
    logic               accept;
    logic [WIDTH-1:0]   sel_a;
    logic [WIDTH-1:0]   sel_b;
    logic               sel_cin;
    logic               run;
    logic               done;

    // Grants are suppressed during reset and whenever the adder is busy or holding a result.
    rr_arb #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req        (req_valid),
        .last_grant (last_grant),
        .enable     (rst_n && (state_q == IDLE)),
        .grant      (grant),
        .grant_idx  (grant_idx)
    );

    assign req_ready = grant;
    assign accept    = |(req_valid & grant);

    always_comb begin
        sel_a   = '0;
        sel_b   = '0;
        sel_cin = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                sel_a   = req_a[i*WIDTH +: WIDTH];
                sel_b   = req_b[i*WIDTH +: WIDTH];
                sel_cin = req_cin[i];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = RUN;
            RUN:     if (cnt == CNT_LAST) state_d = DONE;
            DONE:    if (res_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt        <= '0;
            a_sh       <= '0;
            b_sh       <= '0;
            sum_sh     <= '0;
            carry      <= 1'b0;
            id_q       <= '0;
            last_grant <= LAST_INIT;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        a_sh       <= sel_a;
                        b_sh       <= sel_b;
                        sum_sh     <= '0;
                        carry      <= sel_cin;
                        id_q       <= grant_idx;
                        last_grant <= grant_idx;
                        cnt        <= '0;
                    end
                end
                RUN: begin
                    // LSB-first: after WIDTH shifts the first sum bit lands at bit 0.
                    sum_sh <= {fa_s, sum_sh[WIDTH-1:1]};
                    carry  <= fa_cout;
                    a_sh   <= a_sh >> 1;
                    b_sh   <= b_sh >> 1;
                    if (cnt != CNT_LAST) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign run  = (state_q == RUN);
    assign done = (state_q == DONE);

    assign fa_a = run & a_sh[0];
    assign fa_b = run & b_sh[0];
    assign fa_c = run & carry;

    assign res_valid = done;
    assign res_sum   = done ? sum_sh : '0;
    assign res_cout  = done & carry;
    assign res_id    = done ? id_q : '0;

endmodule

// File: tb/tb_serial_add_sched.sv
// tb/tb_serial_add_sched.sv - directed self-checking bench for serial_add_sched with a behavioural full adder
module tb_serial_add_sched;

    localparam int WIDTH = 8;
    localparam int NREQ  = 2;

    logic                  clk;
    logic                  rst_n;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ*WIDTH-1:0] req_a;
    logic [NREQ*WIDTH-1:0] req_b;
    logic [NREQ-1:0]       req_cin;
    logic                  fa_a;
    logic                  fa_b;
    logic                  fa_c;
    logic                  fa_s;
    logic                  fa_cout;
    logic                  res_valid;
    logic                  res_ready;
    logic [WIDTH-1:0]      res_sum;
    logic                  res_cout;
    logic [0:0]            res_id;

    int n_vec = 0;
    int n_err = 0;
    int onehot_bad = 0;

    serial_add_sched #(
        .WIDTH (WIDTH),
        .NREQ  (NREQ)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .fa_a      (fa_a),
        .fa_b      (fa_b),
        .fa_c      (fa_c),
        .fa_s      (fa_s),
        .fa_cout   (fa_cout),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_sum   (res_sum),
        .res_cout  (res_cout),
        .res_id    (res_id)
    );

    assign fa_s    = fa_a ^ fa_b ^ fa_c;
    assign fa_cout = (fa_a & fa_b) | (fa_a & fa_c) | (fa_b & fa_c);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if ($countones(req_ready) > 1) onehot_bad++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int idx, input logic [WIDTH-1:0] a,
                           input logic [WIDTH-1:0] b, input logic cin);
        req_a[idx*WIDTH +: WIDTH] = a;
        req_b[idx*WIDTH +: WIDTH] = b;
        req_cin[idx]   = cin;
        req_valid[idx] = 1'b1;
    endtask

    // Full transaction: accept, WIDTH RUN cycles, DONE (optionally held), back to IDLE.
    task automatic do_add(input int idx, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input logic cin, input logic [WIDTH-1:0] exp_sum, input logic exp_cout,
                          input logic [WIDTH-1:0] exp_fc, input int hold, input string tag);
        logic [WIDTH-1:0] fc;
        int waited;
        set_req(idx, a, b, cin);
        #1;
        waited = 0;
        while (!req_ready[idx] && waited < 50) begin
            step();
            waited++;
        end
        check({tag, "_grant"}, 32'(req_ready[idx]), 32'd1);
        step();
        req_valid[idx] = 1'b0;
        fc = '0;
        for (int k = 0; k < WIDTH; k++) begin
            fc[k] = fa_c;
            check({tag, "_run_noresult"}, 32'(res_valid), 32'd0);
            if (k == 0) check({tag, "_run_noready"}, 32'(req_ready), 32'd0);
            step();
        end
        check({tag, "_latency"}, 32'(res_valid), 32'd1);
        check({tag, "_sum"}, 32'(res_sum), 32'(exp_sum));
        check({tag, "_cout"}, 32'(res_cout), 32'(exp_cout));
        check({tag, "_id"}, 32'(res_id), 32'(idx));
        check({tag, "_carry_trace"}, 32'(fc), 32'(exp_fc));
        for (int h = 0; h < hold; h++) begin
            step();
            check({tag, "_hold_valid"}, 32'(res_valid), 32'd1);
            check({tag, "_hold_sum"}, 32'(res_sum), 32'(exp_sum));
            check({tag, "_hold_cout"}, 32'(res_cout), 32'(exp_cout));
            check({tag, "_hold_noready"}, 32'(req_ready), 32'd0);
        end
        res_ready = 1'b1;
        step();
        check({tag, "_idle"}, 32'(res_valid), 32'd0);
    endtask

    initial begin
        rst_n     = 1'b0;
        req_valid = 2'b01;
        req_a     = '0;
        req_b     = '0;
        req_cin   = '0;
        res_ready = 1'b1;
        step();
        step();
        check("rst_req_ready", 32'(req_ready), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_sum", 32'(res_sum), 32'd0);
        check("rst_res_cout", 32'(res_cout), 32'd0);
        check("rst_res_id", 32'(res_id), 32'd0);
        check("rst_fa", 32'({fa_a, fa_b, fa_c}), 32'd0);
        req_valid = '0;
        rst_n = 1'b1;
        step();

        do_add(0, 8'h35, 8'h4A, 1'b0, 8'h7F, 1'b0, 8'h00, 0, "t1_basic");
        do_add(1, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 8'hFE, 0, "t2_ripple");
        do_add(0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 8'hFF, 0, "t3_cin");

        // Contention right after reset: requester 0 first, then alternation.
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        set_req(0, 8'h01, 8'h02, 1'b0);
        set_req(1, 8'h80, 8'h80, 1'b0);
        #1;
        check("t4_first_grant", 32'(req_ready), 32'h1);
        do_add(0, 8'h01, 8'h02, 1'b0, 8'h03, 1'b0, 8'h00, 0, "t4_a");
        check("t4_second_grant", 32'(req_ready), 32'h2);
        do_add(1, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 8'h00, 0, "t4_b");
        set_req(0, 8'h05, 8'h06, 1'b0);
        set_req(1, 8'h0F, 8'h01, 1'b0);
        #1;
        check("t4_third_grant", 32'(req_ready), 32'h1);
        do_add(0, 8'h05, 8'h06, 1'b0, 8'h0B, 1'b0, 8'h08, 0, "t4_c");
        check("t4_fourth_grant", 32'(req_ready), 32'h2);
        do_add(1, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 8'h1E, 0, "t4_d");

        // Backpressure with another requester waiting.
        set_req(1, 8'h10, 8'h20, 1'b0);
        res_ready = 1'b0;
        do_add(0, 8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 8'h60, 5, "t5_bp");
        check("t5_pending_grant", 32'(req_ready), 32'h2);
        do_add(1, 8'h10, 8'h20, 1'b0, 8'h30, 1'b0, 8'h00, 0, "t5_after");

        // Abort mid-RUN; pointer must return to NREQ-1 so requester 0 wins again.
        set_req(0, 8'hAA, 8'h55, 1'b0);
        #1;
        check("t6_grant", 32'(req_ready), 32'h1);
        step();
        req_valid[0] = 1'b0;
        step();
        step();
        step();
        rst_n = 1'b0;
        step();
        check("t6_rst_valid", 32'(res_valid), 32'd0);
        check("t6_rst_fa", 32'({fa_a, fa_b, fa_c}), 32'd0);
        rst_n = 1'b1;
        step();
        check("t6_idle_valid", 32'(res_valid), 32'd0);
        check("t6_idle_fa", 32'({fa_a, fa_b, fa_c}), 32'd0);
        check("t6_idle_noready", 32'(req_ready), 32'd0);
        set_req(0, 8'h03, 8'h04, 1'b0);
        set_req(1, 8'h01, 8'h01, 1'b0);
        #1;
        check("t6_ptr_reset", 32'(req_ready), 32'h1);
        req_valid[1] = 1'b0;
        do_add(0, 8'h03, 8'h04, 1'b0, 8'h07, 1'b0, 8'h00, 0, "t6_reissue");

        check("req_ready_onehot", 32'(onehot_bad), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
